// File: rtl/life_game_frame_buffer.sv
// Double-buffered Life cell store with CPU word port, bank-swap at frame start, back-bank clear engine and 2-stage VGA pixel pipeline.
// Optional grid-line overlay on dead cells: define LIFE_GAME_GRID_LINES_EN.
module life_game_frame_buffer #(
  parameter int          GRID_W      = 64,
  parameter int          GRID_H      = 48,
  parameter int          CELL_PX     = 10,
  parameter logic [7:0]  COLOR_LIVE  = 8'b000_000_00,
  parameter logic [7:0]  COLOR_EMPTY = 8'b111_111_11,
  parameter logic [7:0]  COLOR_GRID  = 8'b110_110_10,
  localparam int         WPR         = GRID_W / 32,
  localparam int         DEPTH       = GRID_H * WPR,
  localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cell_write,
  input  logic [AW-1:0] cell_address,
  input  logic [31:0]   cell_data_in,
  output logic [31:0]   cell_data_out,
  input  logic          swap_request,
  output logic          swap_pending,
  input  logic          clear_request,
  output logic          clear_busy,
  input  logic          frame_start,
  input  logic [9:0]    x_position,
  input  logic [8:0]    y_position,
  input  logic          inside_video,
  output logic          world_index,
  output logic [7:0]    color
);

  // state | meaning
  // IDLE  | clear engine idle, CPU writes reach the back bank
  // CLEAR | zeroing back[clr_cnt], one word per cycle
  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t    state;
  logic [AW-1:0] clr_cnt;
  logic [31:0]   bank0 [DEPTH];
  logic [31:0]   bank1 [DEPTH];

  logic          pend_any;
  logic          do_swap;
  logic          addr_ok;

  assign pend_any   = swap_pending | swap_request;
  assign do_swap    = frame_start & pend_any & ~clear_busy;
  assign clear_busy = (state == CLEAR);
  assign addr_ok    = ({1'b0, cell_address} < (AW + 1)'(DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      world_index  <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (do_swap) begin
        world_index  <= ~world_index;
        swap_pending <= 1'b0;
      end else begin
        swap_pending <= pend_any;
      end
      case (state)
        IDLE: begin
          if (clear_request) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single back-bank write port shared by the clear engine and the CPU; clear wins.
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cell_address;
    wr_data = cell_data_in;
    if (!reset) begin
      if (clear_busy) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = '0;
      end else if (cell_write && addr_ok) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      if (world_index) bank0[wr_addr] <= wr_data;
      else             bank1[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    cell_data_out = '0;
    if (addr_ok) cell_data_out = world_index ? bank1[cell_address] : bank0[cell_address];
  end

  // Stage 1: pixel to cell coordinates.
  logic [9:0] cx_q;
  logic [8:0] cy_q;
  logic       vid_q;
`ifdef LIFE_GAME_GRID_LINES_EN
  logic       edge_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      cx_q   <= '0;
      cy_q   <= '0;
      vid_q  <= 1'b0;
`ifdef LIFE_GAME_GRID_LINES_EN
      edge_q <= 1'b0;
`endif
    end else begin
      cx_q   <= 10'(x_position / CELL_PX);
      cy_q   <= 9'(y_position / CELL_PX);
      vid_q  <= inside_video;
`ifdef LIFE_GAME_GRID_LINES_EN
      edge_q <= ((x_position % CELL_PX) == 0) || ((y_position % CELL_PX) == 0);
`endif
    end
  end

  // Stage 2: display-bank lookup and colour.
  logic          in_grid;
  logic [AW-1:0] pix_addr;
  logic [31:0]   pix_word;
  logic          pix_bit;

  always_comb begin
    in_grid  = (int'(cx_q) < GRID_W) && (int'(cy_q) < GRID_H);
    pix_addr = AW'(int'(cy_q) * WPR + int'(cx_q[9:5]));
    pix_word = '0;
    if (in_grid) pix_word = world_index ? bank1[pix_addr] : bank0[pix_addr];
    pix_bit  = pix_word[cx_q[4:0]];
  end

`ifndef LIFE_GAME_GRID_LINES_EN
  logic unused_grid_color;
  assign unused_grid_color = ^COLOR_GRID;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      color <= '0;
    end else if (!vid_q) begin
      color <= '0;
    end else if (!in_grid) begin
      color <= COLOR_EMPTY;
    end else if (pix_bit) begin
      color <= COLOR_LIVE;
    end else begin
`ifdef LIFE_GAME_GRID_LINES_EN
      color <= edge_q ? COLOR_GRID : COLOR_EMPTY;
`else
      color <= COLOR_EMPTY;
`endif
    end
  end

endmodule

// File: tb/tb_life_game_frame_buffer.sv
// Self-checking bench for life_game_frame_buffer: cycle model of the bank/swap/clear rules plus literal checks.
module tb_life_game_frame_buffer;

  localparam int DEPTH = 96;
  localparam int AW    = 7;
`ifdef LIFE_GAME_GRID_LINES_EN
  localparam logic [7:0] EDGE_DEAD = 8'hDA;
`else
  localparam logic [7:0] EDGE_DEAD = 8'hFF;
`endif

  logic          clock = 1'b0;
  logic          reset, cell_write, swap_request, clear_request, frame_start, inside_video;
  logic [AW-1:0] cell_address;
  logic [31:0]   cell_data_in, cell_data_out;
  logic          swap_pending, clear_busy, world_index;
  logic [9:0]    x_position;
  logic [8:0]    y_position;
  logic [7:0]    color;

  life_game_frame_buffer dut (
    .clock(clock), .reset(reset), .cell_write(cell_write), .cell_address(cell_address),
    .cell_data_in(cell_data_in), .cell_data_out(cell_data_out), .swap_request(swap_request),
    .swap_pending(swap_pending), .clear_request(clear_request), .clear_busy(clear_busy),
    .frame_start(frame_start), .x_position(x_position), .y_position(y_position),
    .inside_video(inside_video), .world_index(world_index), .color(color)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the two banks and the control state.
  logic [31:0] m_bank  [2][DEPTH];
  bit          m_known [2][DEPTH];
  bit          m_on = 1'b0;
  int          m_wi, m_idx;
  bit          m_pend, m_clr;
  logic [7:0]  e_color;
  bit          e_known;
  int          p_x, p_y;
  bit          p_in;

  function automatic void pixel_expect(input int x, input int y, input bit vin,
                                       output logic [7:0] c, output bit k);
    int cx, cy, w;
    k  = 1'b1;
    cx = x / 10;
    cy = y / 10;
    if (!vin) c = 8'h00;
    else if (cx >= 64 || cy >= 48) c = 8'hFF;
    else begin
      w = cy * 2 + cx / 32;
      k = m_known[m_wi][w];
      if (m_bank[m_wi][w][cx % 32]) c = 8'h00;
      else if (x % 10 == 0 || y % 10 == 0) c = EDGE_DEAD;
      else c = 8'hFF;
    end
  endfunction

  always @(posedge clock) begin
    int  b;
    bit  busy_pre;
    if (reset) begin
      m_on = 1'b1; m_wi = 0; m_pend = 1'b0; m_clr = 1'b0; m_idx = 0;
      e_color = 8'h00; e_known = 1'b1; p_in = 1'b0; p_x = 0; p_y = 0;
    end else if (m_on) begin
      pixel_expect(p_x, p_y, p_in, e_color, e_known);
      p_x = int'(x_position); p_y = int'(y_position); p_in = inside_video;
      b = 1 - m_wi;
      busy_pre = m_clr;
      if (m_clr) begin
        m_bank[b][m_idx] = 32'h0; m_known[b][m_idx] = 1'b1;
        if (m_idx == DEPTH - 1) m_clr = 1'b0; else m_idx++;
      end else begin
        if (cell_write && int'(cell_address) < DEPTH) begin
          m_bank[b][cell_address] = cell_data_in; m_known[b][cell_address] = 1'b1;
        end
        if (clear_request) begin m_clr = 1'b1; m_idx = 0; end
      end
      if (frame_start && (m_pend || swap_request) && !busy_pre) begin
        m_wi = 1 - m_wi; m_pend = 1'b0;
      end else begin
        m_pend = m_pend | swap_request;
      end
    end
  end

  always @(negedge clock) begin
    if (m_on) begin
      check("world_index", 32'(world_index), 32'(m_wi));
      check("swap_pending", 32'(swap_pending), 32'(m_pend));
      check("clear_busy", 32'(clear_busy), 32'(m_clr));
      if (e_known) check("color", 32'(color), 32'(e_color));
      if (int'(cell_address) < DEPTH && m_known[m_wi][cell_address])
        check("cell_data_out", cell_data_out, m_bank[m_wi][cell_address]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    cell_write = 1'b1; cell_address = AW'(a); cell_data_in = d;
    tick();
    cell_write = 1'b0;
  endtask

  task automatic swap_now();
    swap_request = 1'b1; frame_start = 1'b1;
    tick();
    swap_request = 1'b0; frame_start = 1'b0;
  endtask

  task automatic run_clear(output int cnt);
    clear_request = 1'b1;
    tick();
    clear_request = 1'b0;
    cnt = 0;
    while (clear_busy && cnt < 300) begin cnt++; tick(); end
  endtask

  task automatic pix(input string name, input int x, input int y, input bit vin, input logic [7:0] exp);
    x_position = 10'(x); y_position = 9'(y); inside_video = vin;
    tick(2);
    check(name, 32'(color), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1; cell_write = 1'b0; cell_address = '0; cell_data_in = '0;
    swap_request = 1'b0; clear_request = 1'b0; frame_start = 1'b0;
    x_position = '0; y_position = '0; inside_video = 1'b0;
    tick(2);
    check("rst_world_index", 32'(world_index), 32'd0);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_color", 32'(color), 32'd0);
    reset = 1'b0;
    tick();

    // Zero both banks; same-cycle request+frame_start swaps at once.
    run_clear(cnt);
    check("clear_len_init", 32'(cnt), 32'd96);
    swap_now();
    check("same_cycle_swap", 32'(world_index), 32'd1);
    run_clear(cnt);
    swap_now();
    check("swap_back", 32'(world_index), 32'd0);

    // Writes land in the back bank only.
    write_word(0, 32'h0000_0002);
    cell_address = '0; #1;
    check("display_unchanged", cell_data_out, 32'h0);
    swap_request = 1'b1; tick(); swap_request = 1'b0;
    tick(3);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("after_swap_wi", 32'(world_index), 32'd1);
    check("after_swap_data", cell_data_out, 32'h2);

    // Long pending, merged repeats.
    for (int i = 0; i < 1000; i++) begin
      swap_request = (i == 0 || i == 500);
      tick();
    end
    swap_request = 1'b0;
    check("pending_wi", 32'(world_index), 32'd1);
    check("pending_flag", 32'(swap_pending), 32'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("pending_applied_wi", 32'(world_index), 32'd0);
    check("pending_cleared", 32'(swap_pending), 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("merged_one_swap", 32'(world_index), 32'd0);

    // Clear of a full back bank, with dropped write, ignored request and deferred swap.
    for (int i = 0; i < DEPTH; i++) write_word(i, 32'hFFFF_FFFF);
    clear_request = 1'b1; tick(); clear_request = 1'b0;
    cnt = 0;
    while (clear_busy && cnt < 300) begin
      cnt++;
      cell_write = (cnt == 10); cell_address = 7'd5; cell_data_in = 32'h1234_5678;
      swap_request = (cnt == 20); frame_start = (cnt == 20);
      clear_request = (cnt == 30);
      tick();
      cell_write = 1'b0; swap_request = 1'b0; frame_start = 1'b0; clear_request = 1'b0;
    end
    check("clear_len", 32'(cnt), 32'd96);
    check("swap_deferred", 32'(swap_pending), 32'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("deferred_applied", 32'(world_index), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      cell_address = AW'(i); #1;
      check("cleared_word", cell_data_out, 32'h0);
    end

    // Pixel pipeline: cell (1,0) live in bank 0.
    write_word(0, 32'h0000_0002);
    swap_now();
    cell_address = '0;
    for (int x = 10; x < 20; x++) pix("live_cell", x, 0, 1'b1, 8'h00);
    pix("dead_cell_edge", 20, 0, 1'b1, EDGE_DEAD);
    pix("dead_cell_inner", 25, 3, 1'b1, 8'hFF);
    pix("blank", 15, 0, 1'b0, 8'h00);
    pix("out_of_grid_x", 650, 3, 1'b1, 8'hFF);
    pix("grid_line", 30, 5, 1'b1, EDGE_DEAD);
    pix("grid_inner", 31, 5, 1'b1, 8'hFF);

    // Streamed sweep over a second pattern.
    write_word(1, 32'h8000_0001);
    write_word(95, 32'hA5A5_0F0F);
    write_word(50, 32'h0000_0100);
    swap_now();
    for (int r = 0; r < 3; r++) begin
      for (int x = 0; x < 660; x++) begin
        x_position = 10'(x);
        y_position = (r == 0) ? 9'd0 : (r == 1) ? 9'd255 : 9'd479;
        inside_video = (x < 640);
        tick();
      end
    end
    inside_video = 1'b0;

    // Reset in the middle of a clear of bank 0.
    for (int i = 0; i < DEPTH; i++) write_word(i, 32'hFFFF_FFFF);
    clear_request = 1'b1; tick(); clear_request = 1'b0;
    cnt = 1;
    while (cnt < 41 && clear_busy) begin cnt++; tick(); end
    check("reached_cnt40", 32'(cnt), 32'd41);
    reset = 1'b1; tick(); reset = 1'b0;
    check("busy_after_reset", 32'(clear_busy), 32'd0);
    check("wi_after_reset", 32'(world_index), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cell_address = AW'(i); #1;
      check("partial_clear", cell_data_out, (i < 40) ? 32'h0 : 32'hFFFF_FFFF);
    end
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/life_game_frame_buffer.md
Name: life_game_frame_buffer

Overview:
Parametrised, double-buffered cell-world store for the Life game device. The CPU reads the displayed generation and writes the next generation through a word port. A VGA pixel pipeline renders the displayed bank. Bank swaps are requested by software and applied only at frame start to avoid tearing, and a hardware clear engine zeroes the back bank.

Parameters:
GRID_W, 64, cells per row; multiple of 32.
GRID_H, 48, rows.
CELL_PX, 10, pixel edge of one cell.
COLOR_LIVE, 8'b000_000_00, RGB332 colour of a live cell.
COLOR_EMPTY, 8'b111_111_11, RGB332 colour of a dead cell.
COLOR_GRID, 8'b110_110_10, RGB332 colour of grid lines (optional feature only).
Derived localparams: WPR = GRID_W/32 words per row; DEPTH = GRID_H*WPR; AW = clog2(DEPTH).

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
cell_write  in  1  write strobe, back bank.
cell_address  in  AW  word address = row*WPR + (col/32); bit (col%32) within the word.
cell_data_in  in  32  write data.
cell_data_out  out  32  combinational read of the displayed bank at cell_address.
swap_request  in  1  one-cycle pulse; request a bank swap.
swap_pending  out  1  swap requested, not yet applied.
clear_request  in  1  one-cycle pulse; start zeroing the back bank.
clear_busy  out  1  clear engine active.
frame_start  in  1  one-cycle pulse from the VGA timing at start of vertical blank.
x_position  in  10  current pixel column.
y_position  in  9  current pixel row.
inside_video  in  1  active-video flag.
world_index  out  1  displayed bank (0/1).
color  out  8  registered RGB332 pixel.

Behaviour:
- Reset: world_index=0, swap_pending=0, clear_busy=0, clear counter=0, color=0, pipeline valid bits=0. Memory contents are not reset.
- Banks: display bank = world_index; back bank = !world_index. CPU reads go to the display bank only; CPU writes go to the back bank only.
- Swap: swap_request sets swap_pending. A swap is applied on a cycle where frame_start && swap_pending && !clear_busy. On that cycle: world_index toggles at the edge and swap_pending clears.
  - swap_request and frame_start in the same cycle: swap applies that cycle.
  - Repeated requests while pending: merged into one swap.
  - Clear busy at frame_start: swap deferred to the next frame_start.
- Clear FSM, IDLE/CLEAR:
  - IDLE: clear_request starts CLEAR with counter=0.
  - CLEAR: writes 0 to back[counter] each cycle and increments the counter. After writing DEPTH-1, returns to IDLE.
  - clear_busy is high for exactly DEPTH cycles.
  - clear_request while busy: ignored.
  - CPU writes while busy: dropped.
  - Reset mid-clear: FSM returns to IDLE; partial zeroing remains.
- Pixel pipeline, 2-cycle latency:
  - S1 registers cx = x_position/CELL_PX, cy = y_position/CELL_PX, and the delayed inside_video.
  - S2 reads the display-bank word {cy, cx/32}, selects bit cx%32, and registers color.
  - color = 0 when delayed inside_video=0.
  - Pixels with cx>=GRID_W or cy>=GRID_H output COLOR_EMPTY.
  - Otherwise the pixel is COLOR_LIVE if the bit is 1, else COLOR_EMPTY.
  - A swap mid-line takes effect on the next S2 read. Swaps occur only during blanking, so no visible tearing.
- Widths: all divisions are by constants; a write address >= DEPTH is ignored.

Optional Feature:
LIFE_GAME_GRID_LINES_EN.
- Defined: S1 also registers edge = (x_position%CELL_PX==0) || (y_position%CELL_PX==0). An in-grid dead-cell pixel on an edge outputs COLOR_GRID. Live cells and out-of-grid pixels are unchanged. Latency stays 2.
- Undefined: no modulo logic; dead cells are always COLOR_EMPTY.

Test Plan:
1. Reset, write 32'h0000_0002 to address 0 with world_index=0 → cell_data_out@0 still reads back 0 (display bank). Pulse swap_request, then frame_start → world_index=1, cell_data_out@0=32'h2.
2. swap_request with no frame_start for 1000 cycles → world_index unchanged, swap_pending=1. Next frame_start → toggle, pending=0.
3. clear_request with back bank filled with 32'hFFFF_FFFF → clear_busy high for exactly 96 cycles (defaults). After swap, all 96 words read 0. A CPU write at cycle 10 of the clear is absent afterwards.
4. Live cell (1,0) displayed; drive x=10..19, y=0, inside_video=1 → color=8'h00 two cycles after each position. x=20 → 8'hFF. inside_video=0 → 8'h00.
5. Pixel x=650 → cx=65>=GRID_W → COLOR_EMPTY. Reset asserted mid-clear at counter=40 → clear_busy=0 next cycle, words 40..95 keep old data.
6. LIFE_GAME_GRID_LINES_EN defined, dead cell at x=30,y=5 → 8'b110_110_10. At x=31,y=5 → 8'hFF.
